ctrl_mc_fsm: RTL and testbench

- Multicycle control FSM that drives the datapath mux selects and write enables.
- Its outputs feed the 2x1/4x1 select muxes (ALUSrcA, ALUSrcB, PCSource, RegDst, MemToReg), the ALU op code and the register/PC/IR write strobes.
- Supported subset: R-type add/sub/and, addi, beq, j. Any other opcode/funct is a NOP.
- Sits between the instruction register fields and the datapath; the datapath muxes are its consumers.

---
 rtl/ctrl_mc_fsm_pkg.sv | 62 ++++++
 rtl/ctrl_mc_fsm_alu_ctrl.sv | 21 ++
 rtl/ctrl_mc_fsm.sv | 142 ++++++++++++++
 tb/tb_ctrl_mc_fsm.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_mc_fsm_pkg.sv
// Shared definitions for the multicycle control FSM: state encodings, IR field
// constants, ALU op codes, mux select codes and the control word layout.
package ctrl_mc_fsm_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned FIELD_W = 6;
  localparam int unsigned ALUOP_W = 3;
  localparam int unsigned WAIT_W  = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET       = 4'd0,
    ST_FETCH0      = 4'd1,
    ST_FETCH_WAIT  = 4'd2,
    ST_FETCH_LATCH = 4'd3,
    ST_DECODE      = 4'd4,
    ST_EXEC_R      = 4'd5,
    ST_WB_R        = 4'd6,
    ST_EXEC_I      = 4'd7,
    ST_WB_I        = 4'd8,
    ST_BRANCH      = 4'd9,
    ST_JUMP        = 4'd10
  } state_e;

  localparam logic [FIELD_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [FIELD_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [FIELD_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [FIELD_W-1:0] OP_J     = 6'h02;

  localparam logic [FIELD_W-1:0] FN_ADD = 6'h20;
  localparam logic [FIELD_W-1:0] FN_SUB = 6'h22;
  localparam logic [FIELD_W-1:0] FN_AND = 6'h24;

  localparam logic [ALUOP_W-1:0] ALU_PASS_A = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_ADD    = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_SUB    = 3'b010;
  localparam logic [ALUOP_W-1:0] ALU_AND    = 3'b011;

  localparam logic [1:0] SRCB_REG_B   = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Control word presented to the datapath each cycle
  typedef struct packed {
    logic               mem_read;
    logic               ir_write;
    logic               pc_write;
    logic [1:0]         pc_source;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_out_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               reg_write;
  } ctrl_t;

endpackage

// File: rtl/ctrl_mc_fsm_alu_ctrl.sv
// R-type funct decoder: maps funct to an ALU op and flags supported functs.
module ctrl_mc_fsm_alu_ctrl
  import ctrl_mc_fsm_pkg::*;
(
  input  logic [FIELD_W-1:0] funct,
  output logic [ALUOP_W-1:0] alu_op_c,
  output logic               funct_ok_c
);

  always_comb begin
    alu_op_c   = ALU_PASS_A;
    funct_ok_c = 1'b0;
    case (funct)
      FN_ADD: begin alu_op_c = ALU_ADD; funct_ok_c = 1'b1; end
      FN_SUB: begin alu_op_c = ALU_SUB; funct_ok_c = 1'b1; end
      FN_AND: begin alu_op_c = ALU_AND; funct_ok_c = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_mc_fsm.sv
// Multicycle control FSM: Moore-decoded datapath selects and strobes, with
// PCWrite in BRANCH as the single Mealy term (follows zero).
module ctrl_mc_fsm
  import ctrl_mc_fsm_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FIELD_W-1:0] opcode,
  input  logic [FIELD_W-1:0] funct,
  input  logic               zero,
  input  logic               overflow,
  output logic               MemRead,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic [1:0]         PCSource,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               ALUOutWrite,
  output logic               RegDst,
  output logic               MemToReg,
  output logic               RegWrite,
  output logic [STATE_W-1:0] state
);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  ctrl_t               ctrl_c;
  logic [ALUOP_W-1:0]  r_alu_op_c;
  logic                r_funct_ok_c;

  ctrl_mc_fsm_alu_ctrl u_alu_ctrl (
    .funct      (funct),
    .alu_op_c   (r_alu_op_c),
    .funct_ok_c (r_funct_ok_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RESET;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    ctrl_c  = '0;
    case (state_q)
      ST_RESET: state_d = ST_FETCH0;
      ST_FETCH0: begin
        ctrl_c.mem_read = 1'b1;
        wait_d          = WAIT_W'(MEM_WAIT);
        state_d         = (MEM_WAIT > 0) ? ST_FETCH_WAIT : ST_FETCH_LATCH;
      end
      // Counter was loaded with MEM_WAIT, so exit on 1 gives MEM_WAIT cycles here
      ST_FETCH_WAIT: begin
        ctrl_c.mem_read = 1'b1;
        wait_d          = wait_q - WAIT_W'(1);
        if (wait_q <= WAIT_W'(1)) state_d = ST_FETCH_LATCH;
      end
      ST_FETCH_LATCH: begin
        ctrl_c.mem_read  = 1'b1;
        ctrl_c.ir_write  = 1'b1;
        ctrl_c.alu_src_b = SRCB_FOUR;
        ctrl_c.alu_op    = ALU_ADD;
        ctrl_c.pc_source = PCSRC_ALU;
        ctrl_c.pc_write  = 1'b1;
        state_d          = ST_DECODE;
      end
      ST_DECODE: begin
        ctrl_c.alu_src_b     = SRCB_IMM_SH2;
        ctrl_c.alu_op        = ALU_ADD;
        ctrl_c.alu_out_write = 1'b1;
        case (opcode)
          OP_RTYPE: state_d = r_funct_ok_c ? ST_EXEC_R : ST_FETCH0;
          OP_ADDI:  state_d = ST_EXEC_I;
          OP_BEQ:   state_d = ST_BRANCH;
          OP_J:     state_d = ST_JUMP;
          default:  state_d = ST_FETCH0;
        endcase
      end
      // AND cannot overflow; ADD/SUB overflow drops the write-back
      ST_EXEC_R: begin
        ctrl_c.alu_src_a     = 1'b1;
        ctrl_c.alu_src_b     = SRCB_REG_B;
        ctrl_c.alu_op        = r_alu_op_c;
        ctrl_c.alu_out_write = 1'b1;
        state_d = (overflow && (r_alu_op_c != ALU_AND)) ? ST_FETCH0 : ST_WB_R;
      end
      ST_WB_R: begin
        ctrl_c.reg_dst   = 1'b1;
        ctrl_c.reg_write = 1'b1;
        state_d          = ST_FETCH0;
      end
      ST_EXEC_I: begin
        ctrl_c.alu_src_a     = 1'b1;
        ctrl_c.alu_src_b     = SRCB_IMM;
        ctrl_c.alu_op        = ALU_ADD;
        ctrl_c.alu_out_write = 1'b1;
        state_d = overflow ? ST_FETCH0 : ST_WB_I;
      end
      ST_WB_I: begin
        ctrl_c.reg_write = 1'b1;
        state_d          = ST_FETCH0;
      end
      ST_BRANCH: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_REG_B;
        ctrl_c.alu_op    = ALU_SUB;
        ctrl_c.pc_source = PCSRC_ALUOUT;
        ctrl_c.pc_write  = zero;
        state_d          = ST_FETCH0;
      end
      ST_JUMP: begin
        ctrl_c.pc_source = PCSRC_JUMP;
        ctrl_c.pc_write  = 1'b1;
        state_d          = ST_FETCH0;
      end
      default: state_d = ST_FETCH0;
    endcase
  end

  assign MemRead     = ctrl_c.mem_read;
  assign IRWrite     = ctrl_c.ir_write;
  assign PCWrite     = ctrl_c.pc_write;
  assign PCSource    = ctrl_c.pc_source;
  assign ALUSrcA     = ctrl_c.alu_src_a;
  assign ALUSrcB     = ctrl_c.alu_src_b;
  assign ALUOp       = ctrl_c.alu_op;
  assign ALUOutWrite = ctrl_c.alu_out_write;
  assign RegDst      = ctrl_c.reg_dst;
  assign MemToReg    = ctrl_c.mem_to_reg;
  assign RegWrite    = ctrl_c.reg_write;
  assign state       = state_q;

endmodule

// File: tb/tb_ctrl_mc_fsm.sv
// Bench for ctrl_mc_fsm: two builds (MEM_WAIT=0 and 1) checked every cycle
// against a cycle-position model of the instruction timeline.
module tb_ctrl_mc_fsm;

  localparam int C_NOP = 0, C_R = 1, C_I = 2, C_BEQ = 3, C_J = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opc [2];
  logic [5:0] fn  [2];
  logic       zr  [2];
  logic       ov  [2];

  logic       mr [2], irw [2], pcw [2], alusa [2], aow [2], rdst [2], m2r [2], rw [2];
  logic [1:0] pcs [2], alusb [2];
  logic [2:0] aop [2];
  logic [3:0] st [2];

  int tests = 0;
  int fails = 0;
  int k [2] = '{-1, -1};
  int cls [2] = '{0, 0};
  int nwait [2] = '{0, 0};
  bit rnd_en [2] = '{1'b1, 1'b0};
  int r_sel;

  always #5 clk = ~clk;

  ctrl_mc_fsm #(.MEM_WAIT(0)) u_dut0 (
    .clk(clk), .reset(reset), .opcode(opc[0]), .funct(fn[0]), .zero(zr[0]), .overflow(ov[0]),
    .MemRead(mr[0]), .IRWrite(irw[0]), .PCWrite(pcw[0]), .PCSource(pcs[0]), .ALUSrcA(alusa[0]),
    .ALUSrcB(alusb[0]), .ALUOp(aop[0]), .ALUOutWrite(aow[0]), .RegDst(rdst[0]),
    .MemToReg(m2r[0]), .RegWrite(rw[0]), .state(st[0]));

  ctrl_mc_fsm #(.MEM_WAIT(1)) u_dut1 (
    .clk(clk), .reset(reset), .opcode(opc[1]), .funct(fn[1]), .zero(zr[1]), .overflow(ov[1]),
    .MemRead(mr[1]), .IRWrite(irw[1]), .PCWrite(pcw[1]), .PCSource(pcs[1]), .ALUSrcA(alusa[1]),
    .ALUSrcB(alusb[1]), .ALUOp(aop[1]), .ALUOutWrite(aow[1]), .RegDst(rdst[1]),
    .MemToReg(m2r[1]), .RegWrite(rw[1]), .state(st[1]));

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
    end
  endtask

  function automatic int mw_of(input int i);
    return (i == 0) ? 0 : 1;
  endfunction

  function automatic int classify(input logic [5:0] op, input logic [5:0] f);
    if (op == 6'h00 && (f == 6'h20 || f == 6'h22 || f == 6'h24)) return C_R;
    if (op == 6'h08) return C_I;
    if (op == 6'h04) return C_BEQ;
    if (op == 6'h02) return C_J;
    return C_NOP;
  endfunction

  // Does the instruction end at position kk (next cycle is a fresh fetch)?
  function automatic bit ends_at(input int mw, input int kk, input int c,
                                 input logic [5:0] f, input logic o);
    if (kk == mw + 2 && c == C_NOP) return 1'b1;
    if (kk == mw + 3 && (c == C_BEQ || c == C_J)) return 1'b1;
    if (kk == mw + 3 && o && (c == C_I || (c == C_R && f != 6'h24))) return 1'b1;
    return kk >= mw + 4;
  endfunction

  // Expected control word + state at cycle kk of an instruction (kk<0: in reset)
  function automatic logic [18:0] exp_vec(input int mw, input int kk, input int c,
                                          input logic [5:0] f, input logic z);
    logic m, ir, pw, sa, ao, rd, w;
    logic [1:0] ps, sb;
    logic [2:0] op;
    logic [3:0] s;
    {m, ir, pw, sa, ao, rd, w} = '0;
    ps = 2'd0; sb = 2'd0; op = 3'd0; s = 4'd0;
    if (kk < 0) s = 4'd0;
    else if (kk == 0) begin m = 1; s = 4'd1; end
    else if (kk <= mw) begin m = 1; s = 4'd2; end
    else if (kk == mw + 1) begin m = 1; ir = 1; pw = 1; sb = 2'd1; op = 3'd1; s = 4'd3; end
    else if (kk == mw + 2) begin sb = 2'd3; op = 3'd1; ao = 1; s = 4'd4; end
    else if (kk == mw + 3) begin
      case (c)
        C_R: begin
          sa = 1; ao = 1; s = 4'd5;
          op = (f == 6'h20) ? 3'd1 : (f == 6'h22) ? 3'd2 : 3'd3;
        end
        C_I:   begin sa = 1; sb = 2'd2; op = 3'd1; ao = 1; s = 4'd7; end
        C_BEQ: begin sa = 1; op = 3'd2; ps = 2'd1; pw = z; s = 4'd9; end
        C_J:   begin ps = 2'd2; pw = 1; s = 4'd10; end
        default: s = 4'd15;
      endcase
    end else begin
      case (c)
        C_R:     begin rd = 1; w = 1; s = 4'd6; end
        C_I:     begin w = 1; s = 4'd8; end
        default: s = 4'd15;
      endcase
    end
    return {m, ir, pw, ps, sa, sb, op, ao, rd, 1'b0, w, s};
  endfunction

  function automatic logic [18:0] act_vec(input int i);
    return {mr[i], irw[i], pcw[i], pcs[i], alusa[i], alusb[i], aop[i], aow[i],
            rdst[i], m2r[i], rw[i], st[i]};
  endfunction

  // Model: advance each instruction's cycle position on every edge
  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) k[i] = -1;
      else if (k[i] < 0) k[i] = 0;
      else begin
        if (k[i] == mw_of(i) + 2) cls[i] = classify(opc[i], fn[i]);
        if (ends_at(mw_of(i), k[i], cls[i], fn[i], ov[i])) k[i] = 0;
        else k[i] = k[i] + 1;
      end
    end
  end

  // Compare both builds against the model every cycle
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("cycle_vec%0d", i), 32'(act_vec(i)),
            32'(exp_vec(mw_of(i), k[i], cls[i], fn[i], zr[i])));
      if (st[i] == 4'd2) nwait[i]++;
    end
  end

  // Random stimulus: new instruction whenever a build sits in its first fetch cycle
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < 2; i++) begin
      if (rnd_en[i]) begin
        zr[i] = 1'($urandom_range(0, 1));
        ov[i] = ($urandom_range(0, 3) == 0);
        if (k[i] == 0) begin
          r_sel = int'($urandom_range(0, 9));
          fn[i] = 6'($urandom);
          case (r_sel)
            0, 1, 2: begin opc[i] = 6'h00; fn[i] = 6'h20 + 6'(2 * $urandom_range(0, 2)); end
            3, 4:    opc[i] = 6'h08;
            5, 6:    opc[i] = 6'h04;
            7:       opc[i] = 6'h02;
            8:       opc[i] = 6'($urandom);
            default: opc[i] = 6'h00;
          endcase
        end
      end
    end
  end

  task automatic nstep(input logic [3:0] s, input string nm);
    @(negedge clk);
    check(nm, 32'(st[1]), 32'(s));
  endtask

  initial begin
    reset = 1'b1;
    opc[0] = 6'h3F; fn[0] = 6'h00; zr[0] = 1'b0; ov[0] = 1'b0;
    opc[1] = 6'h00; fn[1] = 6'h22; zr[1] = 1'b0; ov[1] = 1'b0;

    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("reset_all_zero", 32'(act_vec(1)), 32'd0);
    end
    #1 reset = 1'b0;

    // R-type SUB, no overflow
    nstep(4'd1, "sub_fetch0");
    nstep(4'd2, "sub_fetch_wait");
    check("wait_memread", 32'(mr[1]), 32'd1);
    check("wait_no_irwrite", 32'({irw[1], pcw[1]}), 32'd0);
    nstep(4'd3, "sub_latch");
    check("latch_ir_pc_write", 32'({irw[1], pcw[1], alusb[1]}), 32'b1101);
    nstep(4'd4, "sub_decode");
    nstep(4'd5, "sub_exec");
    check("sub_exec_ctl", 32'({aop[1], alusa[1], alusb[1]}), 32'b010100);
    nstep(4'd6, "sub_wb");
    check("sub_wb_ctl", 32'({rw[1], rdst[1], m2r[1]}), 32'b110);
    nstep(4'd1, "sub_back_fetch0_6cyc");

    // addi with overflow: write-back dropped
    opc[1] = 6'h08; ov[1] = 1'b1;
    nstep(4'd2, "addi_wait");
    nstep(4'd3, "addi_latch");
    nstep(4'd4, "addi_decode");
    nstep(4'd7, "addi_exec");
    check("addi_exec_no_regwrite", 32'(rw[1]), 32'd0);
    nstep(4'd1, "addi_ovf_to_fetch0");
    check("addi_ovf_no_regwrite", 32'(rw[1]), 32'd0);

    // beq taken then not taken
    opc[1] = 6'h04; ov[1] = 1'b0; zr[1] = 1'b1;
    nstep(4'd2, "beq_t_wait"); nstep(4'd3, "beq_t_latch"); nstep(4'd4, "beq_t_decode");
    nstep(4'd9, "beq_taken");
    check("beq_taken_pc", 32'({pcw[1], pcs[1]}), 32'b101);
    nstep(4'd1, "beq_t_fetch0");
    zr[1] = 1'b0;
    nstep(4'd2, "beq_n_wait"); nstep(4'd3, "beq_n_latch"); nstep(4'd4, "beq_n_decode");
    nstep(4'd9, "beq_not_taken");
    check("beq_not_taken_pc", 32'({pcw[1], pcs[1]}), 32'b001);
    nstep(4'd1, "beq_n_fetch0");

    // jump, then an unsupported opcode
    opc[1] = 6'h02;
    nstep(4'd2, "j_wait"); nstep(4'd3, "j_latch"); nstep(4'd4, "j_decode");
    nstep(4'd10, "jump");
    check("jump_pc", 32'({pcw[1], pcs[1]}), 32'b110);
    nstep(4'd1, "j_fetch0");
    opc[1] = 6'h3F;
    nstep(4'd2, "nop_wait"); nstep(4'd3, "nop_latch"); nstep(4'd4, "nop_decode");
    check("nop_decode_no_strobes", 32'({pcw[1], rw[1], irw[1]}), 32'd0);
    nstep(4'd1, "nop_to_fetch0");

    // Async reset in the middle of EXEC_R
    opc[1] = 6'h00; fn[1] = 6'h20;
    nstep(4'd2, "add_wait"); nstep(4'd3, "add_latch"); nstep(4'd4, "add_decode");
    nstep(4'd5, "add_exec");
    #2 reset = 1'b1;
    #1 check("async_reset_mid_exec", 32'(act_vec(1)), 32'd0);
    @(negedge clk);
    #1 reset = 1'b0;
    rnd_en[1] = 1'b1;

    // Random run with occasional asynchronous reset pulses
    for (int n = 0; n < 25; n++) begin
      repeat ($urandom_range(20, 120)) @(posedge clk);
      #3 reset = 1'b1;
      #1 check("async_reset_b0", 32'(act_vec(0)), 32'd0);
      check("async_reset_b1", 32'(act_vec(1)), 32'd0);
      @(negedge clk);
      #2 reset = 1'b0;
    end
    repeat (50) @(posedge clk);
    @(negedge clk);

    check("mw0_never_waits", 32'(nwait[0]), 32'd0);
    check("mw1_waits_seen", 32'(nwait[1] > 0), 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
